// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage registers.
package pipe_pkg;

  // Packed control bundle carried from decode to execute.
  typedef struct packed {
    logic       resultSrc;
    logic       memWrite;
    logic [1:0] memType;
    logic       AUIPC;
    logic       branchSrc;
    logic [3:0] ALUCtrl;
    logic       JALR;
    logic [2:0] funct3;
    logic       memSign;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  // Occupancy of a stage buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/stage_skid_buf.sv
// Generic pipeline stage buffer with valid/ready handshake and flush.
// SKID != 0: two entries, registered ready_o (no path from ready_i).
// SKID == 0: single entry, combinational ready_o.
// All state updates on the falling edge; reset is synchronous active-low.
module stage_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = 8,
  parameter int unsigned SKID      = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [PAYLOAD_W-1:0] data_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [PAYLOAD_W-1:0] data_o
);

  state_e                 state_q, state_d;
  logic [PAYLOAD_W-1:0]   main_q, main_d;
  logic [PAYLOAD_W-1:0]   skid_q, skid_d;
  logic                   rdy_q;
  logic                   accept;
  logic                   drain;

  assign valid_o = (state_q != ST_EMPTY);
  assign data_o  = main_q;
  assign ready_o = (SKID != 0) ? rdy_q : (!valid_o || ready_i);
  assign accept  = valid_i && ready_o;
  assign drain   = valid_o && ready_i;

  // Next-state: flush squashes everything, including a same-edge accept.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_d  = data_i;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_d = data_i;
          end else if (accept && (SKID != 0)) begin
            state_d = ST_FULL;
            skid_d  = data_i;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // ready_o is low here, so no accept can coincide
          if (drain) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State registers, falling edge with synchronous reset.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= (state_d != ST_FULL);
    end
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// Decode-to-execute pipeline register: handshake, skid buffer, flush-to-bubble
// and a saturating bubble counter. Ctrl is zeroed whenever the output is a bubble
// so memWrite/branch/JALR stay inert on squashed or empty slots.
module id_ex_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CTRL_WIDTH = 15,
  parameter int unsigned REG_IDX_W  = 5,
  parameter int unsigned SKID       = 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  validD_i,
  output logic                  readyD_o,
  input  logic                  flushE_i,
  input  logic [CTRL_WIDTH-1:0] ctrlD_i,
  input  logic [DATA_WIDTH-1:0] PCD_i,
  input  logic [DATA_WIDTH-1:0] RD1D_i,
  input  logic [DATA_WIDTH-1:0] RD2D_i,
  input  logic [DATA_WIDTH-1:0] ImmExtD_i,
  input  logic [REG_IDX_W-1:0]  rs1D_i,
  input  logic [REG_IDX_W-1:0]  rs2D_i,
  input  logic [REG_IDX_W-1:0]  rdD_i,
  output logic                  validE_o,
  input  logic                  readyE_i,
  output logic [CTRL_WIDTH-1:0] ctrlE_o,
  output logic [DATA_WIDTH-1:0] PCE_o,
  output logic [DATA_WIDTH-1:0] RD1E_o,
  output logic [DATA_WIDTH-1:0] RD2E_o,
  output logic [DATA_WIDTH-1:0] ImmExtE_o,
  output logic [REG_IDX_W-1:0]  rs1E_o,
  output logic [REG_IDX_W-1:0]  rs2E_o,
  output logic [REG_IDX_W-1:0]  rdE_o,
  output logic [CNT_WIDTH-1:0]  bubbleCnt_o
);

  localparam int unsigned PAYLOAD_W = CTRL_WIDTH + 4 * DATA_WIDTH + 3 * REG_IDX_W;

  logic [PAYLOAD_W-1:0]  payload_d;
  logic [PAYLOAD_W-1:0]  payload_q;
  logic [CTRL_WIDTH-1:0] ctrl_raw;
  logic [CNT_WIDTH-1:0]  bubble_cnt_q;

  assign payload_d = {ctrlD_i, PCD_i, RD1D_i, RD2D_i, ImmExtD_i, rs1D_i, rs2D_i, rdD_i};

  stage_skid_buf #(
    .PAYLOAD_W (PAYLOAD_W),
    .SKID      (SKID)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flushE_i),
    .valid_i (validD_i),
    .ready_o (readyD_o),
    .data_i  (payload_d),
    .valid_o (validE_o),
    .ready_i (readyE_i),
    .data_o  (payload_q)
  );

  assign {ctrl_raw, PCE_o, RD1E_o, RD2E_o, ImmExtE_o, rs1E_o, rs2E_o, rdE_o} = payload_q;
  assign ctrlE_o     = validE_o ? ctrl_raw : '0;
  assign bubbleCnt_o = bubble_cnt_q;

  // Count edges that see a bubble at the output; saturate, clear only on reset.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
    end else if (!validE_o && (bubble_cnt_q != '1)) begin
      bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

endmodule
